// File: rtl/hmc_test_pkg.sv
// Shared types and default constants for the bus-side result monitor.
package hmc_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } monitor_state_t;

   localparam logic [15:0] RESULT_ADDR_DEF = 16'h0042;
   localparam logic [7:0]  PASS_VALUE_DEF  = 8'hCF;

endpackage

// File: rtl/trap_detector.sv
// Detects the "JMP *" self-loop: a period-3 read address pattern repeated
// TRAP_REPEAT times in a row. trap is a combinational pulse on the deciding read.
module trap_detector #(
   parameter int TRAP_REPEAT = 6
) (
   input  logic        ph1,
   input  logic        reset,
   input  logic        clear,
   input  logic        rd_strobe,
   input  logic [15:0] address,
   output logic        trap
);

   localparam int MW = $clog2(TRAP_REPEAT + 1);

   logic [15:0]   r_h0;
   logic [15:0]   r_h1;
   logic [15:0]   r_h2;
   logic [1:0]    r_valid_cnt;
   logic [MW-1:0] r_match_cnt;
   logic          w_match;

   // Compare the current read against the read three reads back.
   always_comb begin
      w_match = 1'b0;
      trap    = 1'b0;
      if (rd_strobe && (r_valid_cnt == 2'd3) && (address == r_h2)) begin
         w_match = 1'b1;
         trap    = (r_match_cnt == MW'(TRAP_REPEAT - 1));
      end else begin
         w_match = 1'b0;
         trap    = 1'b0;
      end
   end

   // History shifts only on reads; writes leave both history and streak alone.
   always_ff @(posedge ph1) begin
      if (reset || clear) begin
         r_h0        <= 16'h0000;
         r_h1        <= 16'h0000;
         r_h2        <= 16'h0000;
         r_valid_cnt <= 2'd0;
         r_match_cnt <= '0;
      end else if (rd_strobe) begin
         r_h0 <= address;
         r_h1 <= r_h0;
         r_h2 <= r_h1;
         if (r_valid_cnt != 2'd3) begin
            r_valid_cnt <= r_valid_cnt + 2'd1;
         end
         if (!w_match) begin
            r_match_cnt <= '0;
         end else if (r_match_cnt != '1) begin
            r_match_cnt <= r_match_cnt + MW'(1);
         end
      end
   end

endmodule

// File: rtl/result_monitor.sv
// Bus-side test monitor: latches the mailbox result, detects the end-of-test
// self-loop and issues a registered PASS/FAIL/TIMEOUT verdict.
module result_monitor
   import hmc_test_pkg::*;
#(
   parameter logic [15:0] RESULT_ADDR    = RESULT_ADDR_DEF,
   parameter logic [7:0]  PASS_VALUE     = PASS_VALUE_DEF,
   parameter int          TIMEOUT_CYCLES = 50,
   parameter int          TRAP_REPEAT    = 6,
   parameter int          CW             = 16
) (
   input  logic          ph1,
   input  logic          reset,
   input  logic          start,
   input  logic [15:0]   address,
   input  logic [7:0]    data_out,
   input  logic          read_en,
   output logic [7:0]    result,
   output logic          result_valid,
   output logic [CW-1:0] cycles,
   output logic          trap,
   output logic          done,
   output logic          pass,
   output logic          fail,
   output logic          timeout
);

   monitor_state_t r_state;
   logic [7:0]     r_result;
   logic           r_result_valid;
   logic [CW-1:0]  r_cycles;
   logic           r_trap;
   logic           r_done;
   logic           r_pass;
   logic           r_fail;
   logic           r_timeout;

   logic           w_in_run;
   logic           w_rd_strobe;
   logic           w_mbox_wr;
   logic           w_trap_hit;
   logic           w_last_cycle;
   logic           w_eff_valid;
   logic [7:0]     w_eff_result;

   // Bus decode; a mailbox write on the deciding edge bypasses into the verdict.
   always_comb begin
      w_in_run     = (r_state == ST_RUN);
      w_rd_strobe  = w_in_run && read_en;
      w_mbox_wr    = w_in_run && !read_en && (address == RESULT_ADDR);
      w_last_cycle = (r_cycles == CW'(TIMEOUT_CYCLES - 1));
      if (w_mbox_wr) begin
         w_eff_result = data_out;
         w_eff_valid  = 1'b1;
      end else begin
         w_eff_result = r_result;
         w_eff_valid  = r_result_valid;
      end
   end

   trap_detector #(
      .TRAP_REPEAT (TRAP_REPEAT)
   ) u_trap_detector (
      .ph1       (ph1),
      .reset     (reset),
      .clear     (start),
      .rd_strobe (w_rd_strobe),
      .address   (address),
      .trap      (w_trap_hit)
   );

   // Verdict FSM with mailbox latch and saturating run-cycle counter.
   always_ff @(posedge ph1) begin
      if (reset || start) begin
         r_state        <= reset ? ST_IDLE : ST_RUN;
         r_result       <= 8'h00;
         r_result_valid <= 1'b0;
         r_cycles       <= '0;
         r_trap         <= 1'b0;
         r_done         <= 1'b0;
         r_pass         <= 1'b0;
         r_fail         <= 1'b0;
         r_timeout      <= 1'b0;
      end else if (w_in_run) begin
         if (r_cycles != '1) begin
            r_cycles <= r_cycles + CW'(1);
         end
         if (w_mbox_wr) begin
            r_result       <= data_out;
            r_result_valid <= 1'b1;
         end
         // Trap wins over timeout when both land on the same edge.
         if (w_trap_hit) begin
            r_trap <= 1'b1;
            r_done <= 1'b1;
            if (w_eff_valid && (w_eff_result == PASS_VALUE)) begin
               r_state <= ST_PASS;
               r_pass  <= 1'b1;
            end else begin
               r_state <= ST_FAIL;
               r_fail  <= 1'b1;
            end
         end else if (w_last_cycle) begin
            r_state   <= ST_TIMEOUT;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
         end
      end
   end

   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign cycles       = r_cycles;
   assign trap         = r_trap;
   assign done         = r_done;
   assign pass         = r_pass;
   assign fail         = r_fail;
   assign timeout      = r_timeout;

endmodule

// File: tb/tb_result_monitor.sv
// Scoreboard bench for result_monitor: a queue-based reference model predicts
// each run's verdict; a separate monitor pops and compares when done rises.
module tb_result_monitor;

   localparam int TIMEOUT_CYCLES = 50;
   localparam int TRAP_REPEAT    = 6;
   localparam int RUN_LEN        = 56;

   logic        ph1 = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] address;
   logic [7:0]  data_out;
   logic        read_en;
   logic [7:0]  result;
   logic        result_valid;
   logic [15:0] cycles;
   logic        trap;
   logic        done;
   logic        pass;
   logic        fail;
   logic        timeout;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int verdicts = 0;
   int pushed   = 0;

   typedef struct {
      bit          rd;
      logic [15:0] a;
      logic [7:0]  d;
   } op_t;

   typedef struct {
      int          n;
      bit          p;
      bit          f;
      bit          t;
      bit          trap;
      logic [7:0]  res;
      bit          rv;
      int          cycles;
      int          done_cyc;
   } exp_t;

   op_t  ops_q[$];
   exp_t exp_q[$];

   result_monitor #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TRAP_REPEAT    (TRAP_REPEAT)
   ) dut (
      .ph1          (ph1),
      .reset        (reset),
      .start        (start),
      .address      (address),
      .data_out     (data_out),
      .read_en      (read_en),
      .result       (result),
      .result_valid (result_valid),
      .cycles       (cycles),
      .trap         (trap),
      .done         (done),
      .pass         (pass),
      .fail         (fail),
      .timeout      (timeout)
   );

   initial forever #5 ph1 = ~ph1;

   always @(posedge ph1) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic op_t rd(input logic [15:0] a);
      op_t o;
      o.rd = 1'b1; o.a = a; o.d = 8'h00;
      return o;
   endfunction

   function automatic op_t wr(input logic [15:0] a, input logic [7:0] d);
      op_t o;
      o.rd = 1'b0; o.a = a; o.d = d;
      return o;
   endfunction

   // Reference: keep every read of the run, a streak is a read equal to the
   // read three reads earlier; the run ends at the trap or after 50 cycles.
   function automatic exp_t model();
      exp_t        e;
      logic [15:0] reads[$];
      int          streak = 0;
      int          n;
      e.n = 0; e.p = 0; e.f = 0; e.t = 0; e.trap = 0;
      e.res = 8'h00; e.rv = 0; e.cycles = 0; e.done_cyc = 0;
      for (int k = 0; k < ops_q.size(); k++) begin
         if (ops_q[k].rd) begin
            reads.push_back(ops_q[k].a);
            n = reads.size();
            if (n >= 4 && reads[n-1] == reads[n-4]) streak++;
            else streak = 0;
         end else if (ops_q[k].a == 16'h0042) begin
            e.res = ops_q[k].d;
            e.rv  = 1;
         end
         if (streak == TRAP_REPEAT) begin
            e.trap = 1; e.n = k + 1; e.cycles = k + 1;
            if (e.rv && e.res == 8'hCF) e.p = 1;
            else e.f = 1;
            return e;
         end
         if (k + 1 == TIMEOUT_CYCLES) begin
            e.t = 1; e.n = k + 1; e.cycles = k + 1;
            return e;
         end
      end
      return e;
   endfunction

   task automatic bus_idle();
      read_en = 1'b1; address = 16'hFFFC; data_out = 8'h00;
   endtask

   task automatic drive(input op_t o);
      read_en = o.rd; address = o.a; data_out = o.d;
   endtask

   task automatic pad();
      int k = 0;
      while (ops_q.size() < RUN_LEN) begin
         ops_q.push_back(rd(16'h2000 + 16'(k)));
         k++;
      end
   endtask

   task automatic gen_loop(input bit do_write, input logic [7:0] wdata);
      ops_q.delete();
      if (do_write) ops_q.push_back(wr(16'h0042, wdata));
      for (int r = 0; r < 6; r++) begin
         ops_q.push_back(rd(16'hF000));
         ops_q.push_back(rd(16'hF001));
         ops_q.push_back(rd(16'hF002));
      end
      pad();
   endtask

   task automatic gen_random();
      int          per;
      int          idx = 0;
      logic [15:0] base;
      ops_q.delete();
      per  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 4)) : 3;
      base = 16'($urandom_range(16'h8000, 16'hFF00));
      while (ops_q.size() < RUN_LEN) begin
         case ($urandom_range(0, 9))
            0, 1: ops_q.push_back(wr(16'h0042, ($urandom_range(0, 1) != 0) ? 8'hCF : 8'($urandom)));
            2: ops_q.push_back(wr(16'($urandom), 8'($urandom)));
            3: ops_q.push_back(rd(16'h0042));
            default: begin
               ops_q.push_back(rd(base + 16'(idx % per)));
               idx++;
            end
         endcase
      end
   endtask

   // Optional pre-run (with a CF mailbox write) restarted by a second start.
   task automatic run_ops(input int pre_len);
      exp_t e;
      if (pre_len > 0) begin
         @(negedge ph1); start = 1'b1; bus_idle();
         @(negedge ph1); start = 1'b0; drive(wr(16'h0042, 8'hCF));
         for (int k = 1; k < pre_len; k++) begin
            @(negedge ph1); drive(rd(16'h3000 + 16'(k)));
         end
      end
      e = model();
      @(negedge ph1);
      start = 1'b1; bus_idle();
      e.done_cyc = cyc + 1 + e.n;
      exp_q.push_back(e);
      pushed++;
      foreach (ops_q[k]) begin
         @(negedge ph1); start = 1'b0; drive(ops_q[k]);
      end
      @(negedge ph1); bus_idle();
      repeat (2) @(negedge ph1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_result_valid"}, result_valid, 0);
      chk({tag, "_cycles"}, cycles, 0);
      chk({tag, "_trap"}, trap, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_fail"}, fail, 0);
      chk({tag, "_timeout"}, timeout, 0);
   endtask

   // Monitor: compare on done rising, then check the verdict holds while done stays high.
   initial begin
      exp_t e;
      exp_t last;
      bit   prev_done = 1'b0;
      bit   have_last = 1'b0;
      forever begin
         @(negedge ph1);
         if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got done=1 expected no verdict at cycle %0d", cyc);
            end else begin
               e = exp_q.pop_front();
               verdicts++;
               chk("done_cycle", cyc, e.done_cyc);
               chk("pass", pass, e.p);
               chk("fail", fail, e.f);
               chk("timeout", timeout, e.t);
               chk("trap", trap, e.trap);
               chk("result", result, e.res);
               chk("result_valid", result_valid, e.rv);
               chk("cycles", cycles, e.cycles);
               last = e;
               have_last = 1'b1;
            end
         end else if (done && have_last) begin
            chk("hold_result", result, last.res);
            chk("hold_result_valid", result_valid, last.rv);
            chk("hold_cycles", cycles, last.cycles);
            chk("hold_verdict", {pass, fail, timeout, trap}, {last.p, last.f, last.t, last.trap});
         end
         prev_done = done;
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; bus_idle();
      repeat (2) @(negedge ph1);
      check_zero("reset");
      reset = 1'b0;

      gen_loop(1'b1, 8'hCF); run_ops(0);
      gen_loop(1'b1, 8'h12); run_ops(0);
      gen_loop(1'b0, 8'h00); run_ops(0);

      ops_q.delete(); pad(); run_ops(0);

      // Earlier 00 write, final CF write right before the deciding read.
      ops_q.delete();
      ops_q.push_back(wr(16'h0042, 8'h00));
      for (int r = 0; r < 8; r++) ops_q.push_back(rd(16'hF000 + 16'(r % 3)));
      ops_q.push_back(wr(16'h0042, 8'hCF));
      ops_q.push_back(rd(16'hF002));
      pad();
      run_ops(0);

      gen_loop(1'b0, 8'h00); run_ops(10);

      // Reset at cycle 20 of a run, then IDLE mailbox writes are ignored.
      @(negedge ph1); start = 1'b1; bus_idle();
      @(negedge ph1); start = 1'b0; drive(wr(16'h0042, 8'hCF));
      for (int k = 1; k < 19; k++) begin
         @(negedge ph1); drive(rd(16'h4000 + 16'(k)));
      end
      @(negedge ph1); reset = 1'b1; bus_idle();
      @(negedge ph1); check_zero("mid_reset");
      reset = 1'b0; drive(wr(16'h0042, 8'h5A));
      repeat (3) @(negedge ph1);
      chk("idle_write_result", result, 0);
      chk("idle_write_valid", result_valid, 0);
      bus_idle();
      gen_loop(1'b1, 8'hCF); run_ops(0);

      for (int r = 0; r < 12; r++) begin
         gen_random();
         run_ops(0);
      end

      repeat (5) @(negedge ph1);
      chk("pending", exp_q.size(), 0);
      chk("verdicts", verdicts, pushed);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
